// File: rtl/config_frame_writer.sv
// ============================================================================
// Module  : config_frame_writer
// Brief   : Bitstream word parser that assembles column frames and strobes tiles
// Revision: 1.0
// ============================================================================
`default_nettype none

module config_frame_writer #(
  parameter int          NUMBER_OF_ROWS     = 2,
  parameter int          NUMBER_OF_COLS     = 2,
  parameter int          MAX_FRAMES_PER_COL = 20,
  parameter int          FRAME_BITS_PER_ROW = 32,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD        = 32'hFAB0_FAB0
) (
  input  logic                                         CLK,
  input  logic                                         resetn,
  input  logic [31:0]                                  WriteData,
  input  logic                                         WriteStrobe,
  output logic                                         WriteReady,
  output logic [NUMBER_OF_ROWS*FRAME_BITS_PER_ROW-1:0] FrameData,
  output logic [NUMBER_OF_COLS*MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                                         ConfigActive,
  output logic                                         ConfigError
);

  localparam int          c_CW    = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(NUMBER_OF_ROWS - 1);
  localparam int          c_FW    = NUMBER_OF_ROWS * FRAME_BITS_PER_ROW;
  localparam int          c_NSTB  = NUMBER_OF_COLS * MAX_FRAMES_PER_COL;
  localparam logic [31:0] c_NCOLS = NUMBER_OF_COLS;
  localparam logic [31:0] c_NFRM  = MAX_FRAMES_PER_COL;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_LOAD   = 3'd3,
    S_STROBE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_ready;
  logic              r_active;
  logic              r_error;
  logic              r_valid;
  logic [7:0]        r_col;
  logic [7:0]        r_frame;
  logic [c_CW-1:0]   r_cnt;
  logic [c_FW-1:0]   r_buf;
  logic [c_FW-1:0]   r_frame_data;
  logic [c_NSTB-1:0] r_strobe;

  logic              w_accept;
  logic              w_is_sync;
  logic              w_is_desync;
  logic              w_hdr_valid;
  logic              w_last;
  logic [31:0]       w_idx;
  logic [c_FW-1:0]   w_buf_next;
  logic [c_NSTB-1:0] w_strobe_next;

  assign w_accept    = WriteStrobe & r_ready;
  assign w_is_sync   = (WriteData == SYNC_WORD);
  assign w_is_desync = (WriteData == DESYNC_WORD);
  assign w_hdr_valid = ({24'd0, WriteData[31:24]} < c_NCOLS) &&
                       ({24'd0, WriteData[23:16]} < c_NFRM);
  assign w_last      = (r_state == S_DATA) && w_accept && (r_cnt == c_LAST);
  assign w_idx       = {24'd0, r_col} * c_NFRM + {24'd0, r_frame};

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_is_sync) w_next = S_HEADER;
      S_HEADER: begin
        if (w_accept) begin
          if (w_is_desync)    w_next = S_IDLE;
          else if (!w_is_sync) w_next = S_DATA;
        end
      end
      S_DATA:   if (w_last) w_next = S_LOAD;
      S_LOAD:   w_next = r_valid ? S_STROBE : S_HEADER;
      S_STROBE: w_next = S_HEADER;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_buf_next = r_buf;
    if (r_state == S_DATA && w_accept)
      w_buf_next[int'(r_cnt)*32 +: 32] = WriteData;
    w_strobe_next = '0;
    for (int i = 0; i < c_NSTB; i++)
      w_strobe_next[i] = (w_idx == i);
  end

  // The frame register is loaded on the edge that accepts the last word, so
  // the assembled frame is already on the bus during the LOAD cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_ready      <= 1'b0;
      r_active     <= 1'b0;
      r_error      <= 1'b0;
      r_valid      <= 1'b0;
      r_col        <= '0;
      r_frame      <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_frame_data <= '0;
      r_strobe     <= '0;
    end else begin
      r_ready  <= (w_next == S_IDLE) || (w_next == S_HEADER) || (w_next == S_DATA);
      r_strobe <= (r_state == S_LOAD && r_valid) ? w_strobe_next : '0;
      r_buf    <= w_buf_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_sync) begin
            r_active <= 1'b1;
            r_error  <= 1'b0;
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            if (w_is_desync) begin
              r_active <= 1'b0;
            end else if (!w_is_sync) begin
              r_col   <= WriteData[31:24];
              r_frame <= WriteData[23:16];
              r_valid <= w_hdr_valid;
              r_cnt   <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_accept) r_cnt <= r_cnt + c_CW'(1);
          if (w_last && r_valid) r_frame_data <= w_buf_next;
        end
        S_LOAD: if (!r_valid) r_error <= 1'b1;
        default: ;
      endcase
    end
  end

  assign WriteReady   = r_ready;
  assign FrameData    = r_frame_data;
  assign FrameStrobe  = r_strobe;
  assign ConfigActive = r_active;
  assign ConfigError  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_config_frame_writer.sv
// ============================================================================
// Module  : tb_config_frame_writer
// Brief   : Scoreboard bench for config_frame_writer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_config_frame_writer;

  localparam logic [31:0] c_SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] c_DESYNC = 32'hFAB0_FAB0;

  logic        CLK;
  logic        resetn;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        WriteReady;
  logic [63:0] FrameData;
  logic [39:0] FrameStrobe;
  logic        ConfigActive;
  logic        ConfigError;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [39:0] strobe;
  } exp_t;
  exp_t q[$];

  config_frame_writer dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .WriteData    (WriteData),
    .WriteStrobe  (WriteStrobe),
    .WriteReady   (WriteReady),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .ConfigActive (ConfigActive),
    .ConfigError  (ConfigError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every strobe cycle must match the oldest expected frame exactly.
  always @(negedge CLK) begin
    if (resetn === 1'b1 && FrameStrobe !== 40'd0) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected: FrameStrobe=%h FrameData=%h, none expected", FrameStrobe, FrameData);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (FrameStrobe !== e.strobe || FrameData !== e.data) begin
          failures++;
          $display("FAIL strobe_frame: got strobe=%h data=%h, expected strobe=%h data=%h",
                   FrameStrobe, FrameData, e.strobe, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] d, input int bit_idx);
    exp_t e;
    e.data   = d;
    e.strobe = 40'd1 << bit_idx;
    q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge CLK);
    WriteData   = w;
    WriteStrobe = 1'b1;
    while (WriteReady !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (WriteReady !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: WriteReady=%b after %0d cycles, expected 1", WriteReady, n);
      WriteStrobe = 1'b0;
    end else begin
      @(posedge CLK);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      WriteStrobe = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b1; WriteStrobe = 1'b0; WriteData = '0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({FrameData, FrameStrobe, ConfigActive, ConfigError, WriteReady} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h strobe=%h act=%b err=%b rdy=%b, expected all 0",
               FrameData, FrameStrobe, ConfigActive, ConfigError, WriteReady);
    end
    resetn = 1'b1;
    @(negedge CLK);
    checks++;
    if (WriteReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: WriteReady=%b expected 1", WriteReady);
    end
  endtask

  task automatic test_no_sync;
    send_word(32'h0105_0000);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    idle(4);
    checks++;
    if (FrameData !== 64'd0 || ConfigActive !== 1'b0 || ConfigError !== 1'b0) begin
      failures++;
      $display("FAIL no_sync: data=%h act=%b err=%b, expected 0/0/0", FrameData, ConfigActive, ConfigError);
    end
  endtask

  task automatic test_basic;
    send_word(c_SYNC);
    idle(1);
    checks++;
    if (ConfigActive !== 1'b1) begin
      failures++;
      $display("FAIL sync_active: ConfigActive=%b expected 1", ConfigActive);
    end
    push_exp(64'h1234_5678_DEAD_BEEF, 25);
    send_word(32'h0105_0000);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    @(negedge CLK);
    WriteStrobe = 1'b0;
    checks++;
    if (FrameData !== 64'h1234_5678_DEAD_BEEF || WriteReady !== 1'b0 || FrameStrobe !== 40'd0) begin
      failures++;
      $display("FAIL basic_n1: data=%h rdy=%b strobe=%h, expected 1234_5678_DEAD_BEEF/0/0",
               FrameData, WriteReady, FrameStrobe);
    end
    @(negedge CLK);
    checks++;
    if (FrameStrobe !== (40'd1 << 25) || WriteReady !== 1'b0) begin
      failures++;
      $display("FAIL basic_n2: strobe=%h rdy=%b, expected bit25/0", FrameStrobe, WriteReady);
    end
    @(negedge CLK);
    checks++;
    if (FrameStrobe !== 40'd0 || WriteReady !== 1'b1) begin
      failures++;
      $display("FAIL basic_n3: strobe=%h rdy=%b, expected 0/1", FrameStrobe, WriteReady);
    end
  endtask

  task automatic test_error;
    send_word(32'h0214_0000);
    send_word(32'hAAAA_AAAA);
    send_word(32'hBBBB_BBBB);
    idle(4);
    checks++;
    if (ConfigError !== 1'b1 || FrameData !== 64'h1234_5678_DEAD_BEEF || ConfigActive !== 1'b1) begin
      failures++;
      $display("FAIL err_range: err=%b data=%h act=%b, expected 1/1234_5678_DEAD_BEEF/1",
               ConfigError, FrameData, ConfigActive);
    end
    push_exp(64'h2222_2222_1111_1111, 0);
    send_word(32'h0000_0000);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    idle(4);
    checks++;
    if (q.size() != 0 || ConfigError !== 1'b1) begin
      failures++;
      $display("FAIL err_continue: pending=%0d err=%b, expected 0/1", q.size(), ConfigError);
    end
    send_word(c_DESYNC);
    idle(1);
    checks++;
    if (ConfigActive !== 1'b0 || ConfigError !== 1'b1) begin
      failures++;
      $display("FAIL err_desync: act=%b err=%b, expected 0/1", ConfigActive, ConfigError);
    end
    send_word(c_SYNC);
    idle(1);
    checks++;
    if (ConfigActive !== 1'b1 || ConfigError !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: act=%b err=%b, expected 1/0", ConfigActive, ConfigError);
    end
  endtask

  task automatic test_toggle;
    push_exp(64'h0F0F_0F0F_F0F0_F0F0, 39);
    send_word(32'h0113_0000);
    idle(1);
    send_word(32'hF0F0_F0F0);
    idle(1);
    send_word(32'h0F0F_0F0F);
    @(negedge CLK);
    WriteStrobe = 1'b0;
    checks++;
    if (FrameData !== 64'h0F0F_0F0F_F0F0_F0F0 || WriteReady !== 1'b0) begin
      failures++;
      $display("FAIL toggle_n1: data=%h rdy=%b, expected 0F0F_0F0F_F0F0_F0F0/0", FrameData, WriteReady);
    end
    @(negedge CLK);
    checks++;
    if (FrameStrobe !== (40'd1 << 39)) begin
      failures++;
      $display("FAIL toggle_n2: strobe=%h expected bit39", FrameStrobe);
    end
    idle(2);
    checks++;
    if (q.size() != 0 || WriteReady !== 1'b1) begin
      failures++;
      $display("FAIL toggle_done: pending=%0d rdy=%b, expected 0/1", q.size(), WriteReady);
    end
  endtask

  task automatic test_reset_mid;
    send_word(32'h0003_0000);
    send_word(32'h5555_5555);
    @(negedge CLK);
    WriteStrobe = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if ({FrameData, FrameStrobe, ConfigActive, ConfigError, WriteReady} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: data=%h strobe=%h act=%b err=%b rdy=%b, expected all 0",
               FrameData, FrameStrobe, ConfigActive, ConfigError, WriteReady);
    end
    @(negedge CLK);
    resetn = 1'b1;
    push_exp(64'h7777_7777_6666_6666, 7);
    send_word(c_SYNC);
    send_word(32'h0007_0000);
    send_word(32'h6666_6666);
    send_word(32'h7777_7777);
    idle(4);
    checks++;
    if (q.size() != 0 || FrameData !== 64'h7777_7777_6666_6666) begin
      failures++;
      $display("FAIL midreset_frame: pending=%0d data=%h, expected 0/7777_7777_6666_6666", q.size(), FrameData);
    end
  endtask

  task automatic test_desync;
    send_word(c_DESYNC);
    @(negedge CLK);
    WriteStrobe = 1'b0;
    checks++;
    if (ConfigActive !== 1'b0) begin
      failures++;
      $display("FAIL desync_active: ConfigActive=%b expected 0", ConfigActive);
    end
    send_word(32'h0000_0000);
    send_word(32'h9999_9999);
    send_word(32'h8888_8888);
    idle(4);
    checks++;
    if (FrameData !== 64'h7777_7777_6666_6666 || ConfigActive !== 1'b0 || q.size() != 0) begin
      failures++;
      $display("FAIL desync_ignore: data=%h act=%b pending=%0d, expected 7777_7777_6666_6666/0/0",
               FrameData, ConfigActive, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_basic();
    test_error();
    test_toggle();
    test_reset_mid();
    test_desync();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty: pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
